serial_add_sub: RTL

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: DIGIT bits per clock, LSB digit first; done pulses NDIG cycles after accept.
// No backpressure: start is taken in IDLE or DONE and ignored while busy.
module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DIGIT-1:0] w_ds;
  logic [DIGIT:0]   w_c;
  logic [WIDTH-1:0] w_final;
  logic             w_last;

  // Subtraction is a + ~b + 1, so b is inverted and the carry seeded with cin^op at accept.
  always_comb begin
    w_da   = r_a[r_cnt*DIGIT +: DIGIT];
    w_db   = r_b[r_cnt*DIGIT +: DIGIT];
    w_ds   = '0;
    w_c    = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      w_ds[i]  = w_da[i] ^ w_db[i] ^ w_c[i];
      w_c[i+1] = (w_da[i] & w_db[i]) | (w_c[i] & (w_da[i] ^ w_db[i]));
    end
    w_final = r_work;
    w_final[r_cnt*DIGIT +: DIGIT] = w_ds;
    w_last  = (r_cnt == CW'(NDIG - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{op}};
            r_carry <= cin ^ op;
            r_cnt   <= '0;
            r_work  <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_work  <= w_final;
          r_carry <= w_c[DIGIT];
          if (w_last) begin
            // Top bit of the last digit is the MSB: overflow is carry-in vs carry-out of it.
            sum     <= w_final;
            cout    <= w_c[DIGIT];
            ovf     <= w_c[DIGIT] ^ w_c[DIGIT-1];
            zero    <= (w_final == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
